// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types for the single-port RAM request controller.
package sp_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_CAP,
    RSP
  } ctrl_state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/ram_cmd_fifo.sv
// In-order command queue; pointers carry one extra wrap bit so full/empty
// fall out of a plain subtraction.
module ram_cmd_fifo #(
  parameter int DW    = 7,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] count;

  assign count = wptr - rptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr[PW-2:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[PW-2:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/sp_ram_ctrl.sv
// Decoupled valid/ready front end for a handshake-less single-port RAM:
// queues commands, sequences RAM pins, returns read data.
module sp_ram_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ADDR   = 2,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADDR-1:0]  req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             ram_en,
  output logic [ADDR-1:0]  ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam int CW = 1 + ADDR + WIDTH;

  logic [CW-1:0]    head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             head_we;
  logic [ADDR-1:0]  head_addr;
  logic [WIDTH-1:0] head_wdata;

  ram_cmd_fifo #(
    .DW    (CW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .din   ({req_we, req_addr, req_wdata}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign req_ready  = !full;
  assign head_we    = head[CW-1];
  assign head_addr  = head[CW-2 -: ADDR];
  assign head_wdata = head[WIDTH-1:0];

  ctrl_state_e      state, state_d;
  logic             dispatch;
  logic             ram_en_d;
  logic [ADDR-1:0]  ram_addr_d;
  logic [WIDTH-1:0] ram_din_d;
  logic             rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_d;

  always_comb begin
    state_d     = state;
    dispatch    = 1'b0;
    pop         = 1'b0;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;

    case (state)
      IDLE:     dispatch = 1'b1;
      RD_ISSUE: state_d = RD_CAP;
      RD_CAP: begin
        rsp_data_d  = ram_dout;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        // A consumed response frees the FSM to dispatch in the same cycle.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          dispatch    = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dispatch && !empty) begin
      pop        = 1'b1;
      ram_addr_d = head_addr;
      if (head_we == OP_WR) begin
        ram_en_d  = 1'b1;
        ram_din_d = head_wdata;
        state_d   = IDLE;
      end else begin
        state_d = RD_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_d;
      ram_en    <= ram_en_d;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: behavioural RAM, in-order memory/response model,
// directed scenarios plus randomized traffic with occasional resets.
module tb_sp_ram_ctrl;

  localparam int W = 4;
  localparam int A = 2;
  localparam int Q = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [A-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         ram_en;
  logic [A-1:0] ram_addr;
  logic [W-1:0] ram_din;
  logic [W-1:0] ram_dout;

  sp_ram_ctrl #(.WIDTH(W), .ADDR(A), .QDEPTH(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // External RAM: write when en, registered read data one cycle later.
  logic [W-1:0] ram_mem [1<<A];
  always @(posedge clk) begin
    if (ram_en) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  typedef struct {
    logic [A-1:0] a;
    logic [W-1:0] d;
  } wr_t;

  int           n_cmp = 0;
  int           n_err = 0;
  int           n_acc = 0;
  int           en_total = 0;
  int           en_run = 0;
  int           en_max = 0;
  bit           mon_en = 0;
  bit           prev_rst = 0;
  logic [W-1:0] amem [1<<A];   // memory as seen by the next accepted command
  logic [W-1:0] cmem [1<<A];   // memory as actually written to the RAM
  wr_t          exp_wr [$];
  logic [W-1:0] exp_rsp [$];
  logic [W-1:0] got_rsp [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Observes each upcoming edge at the preceding negedge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_en) begin
        en_total++;
        en_run++;
        if (en_run > en_max) en_max = en_run;
        if (exp_wr.size() == 0) begin
          chk("unexpected_ram_write", ram_en, 1'b0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("ram_wr_addr", ram_addr, e.a);
          chk("ram_wr_data", ram_din, e.d);
          cmem[e.a] = e.d;
        end
      end else begin
        en_run = 0;
      end
      if (prev_rst) begin
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk("post_rst_ram_en", ram_en, 1'b0);
        chk("post_rst_req_ready", req_ready, 1'b1);
      end
      if (rst) begin
        exp_wr.delete();
        exp_rsp.delete();
        for (int i = 0; i < (1<<A); i++) amem[i] = cmem[i];
      end else begin
        if (rsp_valid) begin
          if (exp_rsp.size() == 0) begin
            chk("unexpected_rsp", rsp_valid, 1'b0);
          end else begin
            chk("rsp_data", rsp_data, exp_rsp[0]);
            if (rsp_ready) begin
              got_rsp.push_back(rsp_data);
              void'(exp_rsp.pop_front());
            end
          end
        end
        if (req_valid && req_ready) begin
          n_acc++;
          if (req_we) begin
            wr_t e;
            e.a = req_addr;
            e.d = req_wdata;
            amem[req_addr] = req_wdata;
            exp_wr.push_back(e);
          end else begin
            exp_rsp.push_back(amem[req_addr]);
          end
        end
      end
    end
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [A-1:0] a, input logic [W-1:0] d);
    int t = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && t < 60) begin
      step();
      t++;
    end
    if (t >= 60) chk("issue_timeout_req_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t = 0;
    while (got_rsp.size() < target && t < 200) begin
      step();
      t++;
    end
    chk("rsp_count", got_rsp.size(), target);
  endtask

  int n;
  int base;
  int acc0;

  initial begin
    for (int i = 0; i < (1<<A); i++) begin
      amem[i] = '0;
      cmem[i] = '0;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    step();
    step();
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_req_ready", req_ready, 1'b1);
    mon_en = 1'b1;
    rst = 1'b0;
    step();

    // Write then read the same address, with latency measurement.
    en_total = 0; en_max = 0;
    issue(1'b1, 2'd2, 4'hA);
    chk("wr_cycle1_ram_en", ram_en, 1'b0);
    step();
    chk("wr_cycle2_ram_en", ram_en, 1'b1);
    step();
    chk("wr_cycle3_ram_en", ram_en, 1'b0);
    base = got_rsp.size();
    issue(1'b0, 2'd2, 4'h0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("rd_latency", n, 4);
    chk("rd_data_A", rsp_data, 4'hA);
    wait_rsp(base + 1);
    chk("wr_en_total", en_total, 1);

    // Four back-to-back writes then four reads.
    step();
    en_total = 0; en_max = 0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_req_ready", req_ready, 1'b1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = A'(i); req_wdata = W'(i + 1);
      step();
    end
    req_valid = 1'b0;
    repeat (4) step();
    chk("b2b_en_total", en_total, 4);
    chk("b2b_en_run", en_max, 4);
    base = got_rsp.size();
    for (int i = 0; i < 4; i++) issue(1'b0, A'(i), '0);
    wait_rsp(base + 4);
    for (int i = 0; i < 4; i++) chk("b2b_rd_order", got_rsp[base + i], W'(i + 1));

    // Stalled consumer: five reads fill the queue.
    step();
    rsp_ready = 1'b0;
    base = got_rsp.size();
    issue(1'b0, 2'd0, '0);
    issue(1'b0, 2'd1, '0);
    issue(1'b0, 2'd2, '0);
    issue(1'b0, 2'd3, '0);
    issue(1'b0, 2'd0, '0);
    chk("stall_req_ready_full", req_ready, 1'b0);
    repeat (3) step();
    chk("stall_still_full", req_ready, 1'b0);
    chk("stall_rsp_valid", rsp_valid, 1'b1);
    chk("stall_rsp_held", rsp_data, 4'h1);

    // Full queue with a same-cycle pop: push refused now, accepted next.
    acc0 = n_acc;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = 4'h7;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("full_pop_push_refused", n_acc, acc0);
    chk("full_pop_ready_next", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk("full_pop_push_accepted", n_acc, acc0 + 1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!rsp_valid && n < 20) begin
        step();
        n++;
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      step();
    end
    wait_rsp(base + 5);
    chk("stall_rd0", got_rsp[base + 0], 4'h1);
    chk("stall_rd1", got_rsp[base + 1], 4'h2);
    chk("stall_rd2", got_rsp[base + 2], 4'h3);
    chk("stall_rd3", got_rsp[base + 3], 4'h4);
    chk("stall_rd4", got_rsp[base + 4], 4'h1);

    // Read immediately after write to the same address.
    rsp_ready = 1'b1;
    base = got_rsp.size();
    issue(1'b1, 2'd1, 4'h5);
    issue(1'b0, 2'd1, '0);
    issue(1'b0, 2'd0, '0);
    wait_rsp(base + 2);
    chk("raw_rd1", got_rsp[base], 4'h5);
    chk("raw_rd0", got_rsp[base + 1], 4'h7);

    // Reset while in RD_CAP with two entries queued.
    step();
    base = got_rsp.size();
    issue(1'b0, 2'd3, '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd1;
    step();
    req_addr = 2'd2;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_ram_en", ram_en, 1'b0);
    repeat (12) step();
    chk("mid_rst_no_rsp", got_rsp.size(), base);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      req_valid = $urandom_range(0, 2) != 0;
      req_we    = $urandom_range(0, 1);
      req_addr  = A'($urandom_range(0, 3));
      req_wdata = W'($urandom_range(0, 15));
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk("drain_rsp_left", exp_rsp.size(), 0);
    chk("drain_wr_left", exp_wr.size(), 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sp_ram_ctrl.md
# sp_ram_ctrl

Request-side controller placed directly upstream of the single-port RAM `sp_ram`. It accepts read/write commands over a valid/ready handshake and buffers them in an in-order command queue. It drives the RAM's `en`/`addr`/`din` pins one command at a time and returns read data over a valid/ready response channel. This gives clients a decoupled, backpressured interface to a RAM that has no handshake of its own.

## Interface
- `WIDTH`, 4, data width; must match the RAM.
- `ADDR`, 2, address width; must match the RAM.
- `QDEPTH`, 4, command queue entries; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  queue can accept; equals `!full`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR  command address.
- `req_wdata`  in  WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer accepts the read data.
- `rsp_data`  out  WIDTH  read data.
- `ram_en`  out  1  to RAM `en`; 1 = write, 0 = read.
- `ram_addr`  out  ADDR  to RAM `addr`.
- `ram_din`  out  WIDTH  to RAM `din`.
- `ram_dout`  in  WIDTH  from RAM `dout`; registered, valid one cycle after a read is presented.

## Operation
- Handshakes:
  - A command is accepted when `req_valid && req_ready` at a rising edge.
  - A response transfers when `rsp_valid && rsp_ready`.
- Queue:
  - FIFO of {we, addr, wdata}, strictly in order.
  - `req_ready = !full`. A push is refused when the queue is full, even if a pop occurs in the same cycle.
  - Pointers are ADDR-independent, `$clog2(QDEPTH)+1` bits each; wrap-around is natural.
- FSM states: IDLE, RD_ISSUE, RD_CAP, RSP.
  - IDLE:
    - Queue empty → stay.
    - Head is a write → pop, register `ram_en=1`, `ram_addr`, `ram_din`; stay in IDLE. Back-to-back writes run at 1 per cycle.
    - Head is a read → pop, register `ram_en=0` and `ram_addr`; go to RD_ISSUE.
  - RD_ISSUE: no pop; `ram_en=0`, `ram_addr` held; the RAM samples at the end of this cycle; go to RD_CAP.
  - RD_CAP: capture `ram_dout` into `rsp_data`, set `rsp_valid`; go to RSP.
  - RSP:
    - `rsp_valid=1`; `rsp_data` is held stable.
    - No pop while `!rsp_ready`.
    - On `rsp_ready`: clear `rsp_valid` and act exactly as IDLE in the same cycle, so a pop is permitted.
- `ram_en` is 1 only in the cycle following a write pop; all other cycles drive 0. The RAM therefore reads harmlessly when idle.
- Read-after-write to the same address returns the new data, because the queue is strictly in order.

## Timing
- All outputs except `req_ready` are registered. `req_ready` is combinational from the queue count.
- Reset values:
  - `ram_en=0`, `ram_addr=0`, `ram_din=0`
  - `rsp_valid=0`, `rsp_data=0`
  - queue empty, so `req_ready=1`
  - FSM in IDLE
- Write, accepted at edge E0:
  - popped at E1;
  - `ram_en=1` during cycle 2;
  - the RAM writes at E2.
- Read, accepted at edge E0:
  - popped at E1;
  - address presented in cycle 2;
  - `ram_dout` valid in cycle 3;
  - `rsp_valid=1` in cycle 4.
  - Total: 4 cycles from acceptance to `rsp_valid`.
- Read throughput is at most 1 per 3 cycles, and lower if `rsp_ready` stalls.
- Reset mid-operation:
  - The queue is flushed and the FSM returns to IDLE.
  - `rsp_valid`/`ram_en` are 0 from the cycle after the reset edge.
  - A write whose `ram_en` was already high at the reset edge completes, because the RAM samples it on that same edge.
  - A pending response is dropped.

## Structure
- Package `sp_ram_ctrl_pkg` holds:
  - the state enum `ctrl_state_e` (IDLE, RD_ISSUE, RD_CAP, RSP);
  - localparams `OP_RD=1'b0` and `OP_WR=1'b1`.
- Sub-module `ram_cmd_fifo`: parameterized synchronous FIFO with width `1+ADDR+WIDTH`, depth `QDEPTH`, and outputs full/empty.
- The top level holds the FSM and the RAM-side and response registers.

## Test plan
- Reset, then write `addr=2`, `data=4'hA`, then read `addr=2` → `ram_en` high exactly one cycle; `rsp_data=4'hA` with `rsp_valid` 4 cycles after read acceptance.
- Four back-to-back writes (addresses 0..3, data 1..4) with `req_valid` held high → `req_ready` stays 1; `ram_en` high 4 consecutive cycles; reads return 1,2,3,4 in order.
- Hold `rsp_ready=0`, issue 5 reads → first response held stable; queue fills, `req_ready=0` after the 4th queued entry; each response releases in order as `rsp_ready` pulses.
- Write `addr=1` `data=5` immediately followed by read `addr=1` → `rsp_data=5` (no stale read).
- Queue full while `rsp_ready=1` pops in the same cycle → push is refused that cycle and accepted the next.
- Assert `rst` for 1 cycle while in RD_CAP with 2 entries queued → `rsp_valid=0`, `req_ready=1`, `ram_en=0` next cycle; no response is ever emitted for the flushed commands.
